coin_pulse_sched: RTL and testbench

// - Merges coin requests from several input sources (keyboard coin keys, joystick coin buttons).
// - Queues coin events and replays each one to the game core's coin input as an arcade-timed pulse.
// - Each pulse has a fixed width and a fixed minimum gap, counted in pixel-clock enable ticks (ce).
// - Sits between the input decode logic and the core's in0 coin bit, so quick or simultaneous presses are never lost or merged.

---
 rtl/coin_pulse_sched.sv | 157 +++++++++++++++
 tb/tb_coin_pulse_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_pulse_sched.sv
// coin_pulse_sched: merges level coin requests from NSRC sources, queues each
// rising edge as a separate coin event (saturating at QMAX) and replays them
// one at a time as arcade-timed pulses: PULSE_LEN ce ticks high, then at least
// GAP_LEN+1 ce ticks low.
// Optional feature: define COIN_LOCKOUT_EN to add the i_lockout input, which
// suppresses new events and holds off new pulses while asserted.

module coin_pulse_sched #(
    parameter int NSRC      = 5,
    parameter int TW        = 20,
    parameter int PULSE_LEN = 360000,
    parameter int GAP_LEN   = 360000,
    parameter int QMAX      = 7,
    localparam int PW       = $clog2(QMAX + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ce,
    input  logic [NSRC-1:0] i_req,
`ifdef COIN_LOCKOUT_EN
    input  logic            i_lockout,
`endif
    output logic            o_coin_out,
    output logic [PW-1:0]   o_pending,
    output logic            o_busy,
    output logic            o_drop
);

    localparam int CW = $clog2(NSRC + 1);
    localparam int SW = PW + CW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [NSRC-1:0] r_reqQ1;
    logic [NSRC-1:0] r_reqQ2;
    logic [NSRC-1:0] w_rise;
    logic [CW-1:0]   w_riseCnt;
    logic [SW-1:0]   w_sum;
    logic            w_lockout;
    logic            w_deq;
    logic [PW-1:0]   r_pending;
    logic            r_drop;
    state_t          r_state;
    state_t          w_stateNext;
    logic [TW-1:0]   r_cnt;
    logic [TW-1:0]   w_cntNext;
    logic            r_coinOut;
    logic            w_coinNext;

`ifdef COIN_LOCKOUT_EN
    assign w_lockout = i_lockout;
`else
    assign w_lockout = 1'b0;
`endif

    // Two-stage edge detector on the raw requests; reset to all ones so a source held through reset is not counted.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_reqQ1 <= '1;
            r_reqQ2 <= '1;
        end else begin
            r_reqQ1 <= i_req;
            r_reqQ2 <= r_reqQ1;
        end
    end

    // Count the rising edges this cycle; edges seen while locked out are simply discarded.
    always_comb begin
        w_rise    = w_lockout ? '0 : (r_reqQ1 & ~r_reqQ2);
        w_riseCnt = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_riseCnt = w_riseCnt + CW'(w_rise[i]);
        end
        w_sum = SW'(r_pending) + SW'(w_riseCnt) - SW'(w_deq);
    end

    // Pending-event counter: enqueue and dequeue applied together, saturating at QMAX with a drop strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending <= '0;
            r_drop    <= 1'b0;
        end else if (w_sum > SW'(QMAX)) begin
            r_pending <= PW'(QMAX);
            r_drop    <= 1'b1;
        end else begin
            r_pending <= w_sum[PW-1:0];
            r_drop    <= 1'b0;
        end
    end

    // State register together with the tick counter and the registered coin output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_coinOut <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_coinOut <= w_coinNext;
        end
    end

    // Next-state logic: only advances on ce ticks; starting a pulse consumes one pending event.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_coinNext  = r_coinOut;
        w_deq       = 1'b0;
        if (i_ce) begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_pending != '0) && !w_lockout) begin
                        w_stateNext = ST_PULSE;
                        w_coinNext  = 1'b1;
                        w_cntNext   = TW'(PULSE_LEN - 1);
                        w_deq       = 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        w_stateNext = ST_GAP;
                        w_coinNext  = 1'b0;
                        w_cntNext   = TW'(GAP_LEN - 1);
                    end else begin
                        w_cntNext = r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_cntNext = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                    w_coinNext  = 1'b0;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    // Output decode: busy straight from the state, the rest from registers.
    always_comb begin
        o_busy     = (r_state != ST_IDLE);
        o_coin_out = r_coinOut;
        o_pending  = r_pending;
        o_drop     = r_drop;
    end

endmodule

// File: tb/tb_coin_pulse_sched.sv
// tb_coin_pulse_sched: directed bench for coin_pulse_sched with a pulse
// scoreboard. Each test pushes the coin pulses it expects (width and, for
// back-to-back pulses, the preceding low time, both in clocks); an independent
// monitor measures every pulse the DUT produces and compares it with the queue.
// Build with COIN_LOCKOUT_EN defined to also exercise the lockout input.

module tb_coin_pulse_sched;

    typedef struct {
        int width;
        int gap;
    } pulseExp_t;

    logic       clock;
    logic       reset;
    logic       ce;
    logic [4:0] req;
    logic       coinOut;
    logic [2:0] pending;
    logic       busy;
    logic       drop;
`ifdef COIN_LOCKOUT_EN
    logic       lockout;
`endif

    int        checks     = 0;
    int        failures   = 0;
    int        pulseCount = 0;
    int        dropCount  = 0;
    bit        ceEnable   = 1'b1;
    int        base;
    pulseExp_t sbQ[$];

    coin_pulse_sched #(
        .NSRC(5), .TW(20), .PULSE_LEN(4), .GAP_LEN(3), .QMAX(7)
    ) dut (
        .i_clk(clock),
        .i_reset(reset),
        .i_ce(ce),
        .i_req(req),
`ifdef COIN_LOCKOUT_EN
        .i_lockout(lockout),
`endif
        .o_coin_out(coinOut),
        .o_pending(pending),
        .o_busy(busy),
        .o_drop(drop)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ce generator: one clock in four while enabled, updated on the falling edge.
    initial begin
        int divCnt = 0;
        ce = 1'b0;
        forever begin
            @(negedge clock);
            if (ceEnable) begin
                divCnt = (divCnt + 1) % 4;
                ce = (divCnt == 0);
            end else begin
                ce = 1'b0;
            end
        end
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [4:0] reqVal, input int holdClks);
        @(negedge clock);
        req = reqVal;
        waitClk(holdClks);
    endtask

    task automatic waitCoin(input logic lvl, input int budget, input string nm);
        for (int i = 0; i < budget && coinOut !== lvl; i++) @(negedge clock);
        checkOutput(nm, coinOut, lvl);
    endtask

    task automatic waitDrained(input int budget, input string nm);
        for (int i = 0; i < budget && (sbQ.size() != 0 || busy !== 1'b0); i++) @(negedge clock);
        checkOutput({nm, " queue"}, sbQ.size(), 0);
        checkOutput({nm, " busy"}, busy, 0);
    endtask

    task automatic pushPulse(input int width, input int gap);
        pulseExp_t e;
        e.width = width;
        e.gap   = gap;
        sbQ.push_back(e);
    endtask

    // Pulse monitor: measures high and preceding low time of each pulse and checks it against the scoreboard.
    initial begin
        int        highLen = 0;
        int        lowLen  = 0;
        int        gapSeen = 0;
        bit        prev    = 1'b0;
        pulseExp_t e;
        forever begin
            @(negedge clock);
            if (coinOut === 1'b1) begin
                if (!prev) begin
                    gapSeen = lowLen;
                    lowLen  = 0;
                end
                highLen++;
            end else begin
                if (prev) begin
                    pulseCount++;
                    if (sbQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected pulse: got width %0d expected no pulse", highLen);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("pulse width", highLen, e.width);
                        if (e.gap >= 0) checkOutput("pulse gap", gapSeen, e.gap);
                    end
                    highLen = 0;
                end
                lowLen++;
            end
            prev = (coinOut === 1'b1);
        end
    end

    // Drop strobe counter.
    initial begin
        forever begin
            @(negedge clock);
            if (drop === 1'b1) dropCount++;
        end
    end

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        waitClk(3);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
`ifdef COIN_LOCKOUT_EN
        lockout = 1'b0;
`endif
        waitClk(4);
        checkOutput("reset coin", coinOut, 0);
        checkOutput("reset pending", pending, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset drop", drop, 0);
        reset = 1'b0;
        waitClk(2);

        // T1: single event on req[0]
        $display("[TB] T1 single event");
        pushPulse(16, -1);
        applyStimulus(5'b00001, 1);
        checkOutput("T1 pending t", pending, 0);
        waitClk(1);
        checkOutput("T1 pending t+1", pending, 1);
        req = '0;
        waitCoin(1'b1, 20, "T1 pulse start");
        checkOutput("T1 pending after start", pending, 0);
        waitDrained(60, "T1 drained");
        checkOutput("T1 coin low", coinOut, 0);

        // T2: simultaneous rises on req[0] and req[3]
        $display("[TB] T2 simultaneous events");
        dropCount = 0;
        pushPulse(16, -1);
        pushPulse(16, 16);
        applyStimulus(5'b01001, 2);
        checkOutput("T2 pending", pending, 2);
        req = '0;
        waitCoin(1'b1, 20, "T2 pulse1 start");
        checkOutput("T2 pending after 1st", pending, 1);
        waitDrained(120, "T2 drained");
        checkOutput("T2 pending end", pending, 0);
        checkOutput("T2 drops", dropCount, 0);

        // T3: saturation with ce held low
        $display("[TB] T3 saturation");
        ceEnable  = 1'b0;
        waitClk(2);
        dropCount = 0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(5'b00010, 0);
            applyStimulus(5'b00000, 0);
        end
        waitClk(3);
        checkOutput("T3 pending sat", pending, 7);
        checkOutput("T3 drops", dropCount, 2);
        checkOutput("T3 coin idle", coinOut, 0);
        base = pulseCount;
        pushPulse(16, -1);
        for (int k = 0; k < 6; k++) pushPulse(16, 16);
        ceEnable = 1'b1;
        waitDrained(400, "T3 drained");
        checkOutput("T3 pulses", pulseCount - base, 7);
        checkOutput("T3 pending end", pending, 0);

        // T4: level hold, then a source held through reset
        $display("[TB] T4 level hold");
        base = pulseCount;
        pushPulse(16, -1);
        applyStimulus(5'b00100, 1000);
        req = '0;
        waitDrained(60, "T4 drained");
        checkOutput("T4 pulses", pulseCount - base, 1);
        @(negedge clock);
        req   = 5'b10000;
        reset = 1'b1;
        waitClk(2);
        reset = 1'b0;
        base  = pulseCount;
        waitClk(60);
        checkOutput("T4 held-through-reset pulses", pulseCount - base, 0);
        checkOutput("T4 held-through-reset pending", pending, 0);
        pushPulse(16, -1);
        applyStimulus(5'b00000, 2);
        applyStimulus(5'b10000, 2);
        waitDrained(60, "T4 toggle drained");
        checkOutput("T4 toggle pulses", pulseCount - base, 1);
        req = '0;

        // T5: reset during the second clock of a pulse with three events queued
        $display("[TB] T5 reset mid-pulse");
        ceEnable = 1'b0;
        applyStimulus(5'b00111, 1);
        req = '0;
        waitClk(2);
        checkOutput("T5 pending", pending, 3);
        pushPulse(2, -1);
        ceEnable = 1'b1;
        waitCoin(1'b1, 20, "T5 pulse start");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("T5 coin after reset", coinOut, 0);
        checkOutput("T5 pending after reset", pending, 0);
        checkOutput("T5 busy after reset", busy, 0);
        reset = 1'b0;
        waitClk(2);
        base = pulseCount;
        waitClk(80);
        checkOutput("T5 pulses after reset", pulseCount - base, 0);
        checkOutput("T5 queue", sbQ.size(), 0);

`ifdef COIN_LOCKOUT_EN
        // T6: lockout raised during the first of two queued pulses
        $display("[TB] T6 lockout");
        doReset();
        waitClk(2);
        dropCount = 0;
        base = pulseCount;
        pushPulse(16, -1);
        applyStimulus(5'b00011, 2);
        checkOutput("T6 pending", pending, 2);
        req = '0;
        waitCoin(1'b1, 20, "T6 pulse1 start");
        lockout = 1'b1;
        applyStimulus(5'b01000, 2);
        req = '0;
        waitDrained(60, "T6 first drained");
        waitClk(40);
        checkOutput("T6 locked coin", coinOut, 0);
        checkOutput("T6 locked pending", pending, 1);
        checkOutput("T6 locked pulses", pulseCount - base, 1);
        pushPulse(16, -1);
        lockout = 1'b0;
        waitCoin(1'b1, 20, "T6 pulse2 start");
        waitDrained(60, "T6 second drained");
        waitClk(40);
        checkOutput("T6 total pulses", pulseCount - base, 2);
        checkOutput("T6 pending end", pending, 0);
        checkOutput("T6 drops", dropCount, 0);
`endif

        waitClk(4);
        checkOutput("final queue empty", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
